pq_fpga_tg: RTL and testbench
=============================

Name: pq_fpga_tg

Overview:
- On-FPGA traffic generator and checker for one pq instance, placed between the clock-wizard lock-derived reset and the pq under test.
- Stretches the board reset into a held pq reset, then issues push/pop traffic in two modes: fill-then-drain, or pseudo-random mixed followed by drain.
- Checks min-priority pop ordering and item conservation.
- Exposes status flags and counters for ILA/LED observation.

Parameters:
- DEPTH, QUEUE_DEPTH, pq capacity; the fill phase pushes min(num_ops_i, DEPTH) items.
- DW, pq_pkg::DW, data width.
- LFSR_W, 16, Galois LFSR width, taps x^16+x^14+x^13+x^11+1. DW > LFSR_W: zero-extended; DW < LFSR_W: truncated to LSBs.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- RST_HOLD, 16, cycles pq_rst_no stays low after rst_i deasserts.
- POP_LAT, 1, cycles from pop acceptance to valid pop_data_i (0 = same cycle).
- TIMEOUT, 1024, watchdog limit in cycles (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset (inverted MMCM locked).
- pq_rst_no  out  1  active-low synchronous reset to pq.
- start_i  in  1  level; run begins on IDLE with start_i=1.
- mode_i  in  1  0 = FILL_DRAIN, 1 = MIX; sampled at start.
- num_ops_i  in  16  operation budget; sampled at start.
- push_o  out  1  push request to pq.
- push_rdy_i  in  1  pq push ready.
- pop_o  out  1  pop request to pq.
- pop_rdy_i  in  1  pq pop ready.
- full_i  in  1  pq full.
- empty_i  in  1  pq empty.
- push_data_o  out  DW  data pushed to pq.
- pop_data_i  in  DW  data popped from pq.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; held until next start.
- err_o  out  1  sticky error flag for the current run.
- err_cnt_o  out  16  saturating error count.
- op_cnt_o  out  16  accepted push+pop count.

Behaviour:
- Reset (rst_i=1): state RST_HOLD; LFSR=SEED; all counters 0; push_o=pop_o=busy_o=done_o=err_o=0; pq_rst_no=0; push_data_o=0.
- rst_i asserted in any state, mid-transfer included, aborts at once to RST_HOLD; no partial op survives.
- RST_HOLD: hold counter runs RST_HOLD cycles after rst_i falls, then pq_rst_no=1 and state goes to IDLE.
- IDLE + start_i: latch mode/num_ops; clear counters, err_o, done_o; busy_o=1.
  - num_ops_i=0 goes straight to DRAIN.
  - mode 0 goes to FILL; mode 1 goes to MIX.
- Handshake:
  - A request stays asserted with its data stable until its rdy_i is high.
  - Accept = req & rdy in the same cycle.
  - At most one op outstanding; push_o and pop_o are never both high.
  - LFSR advances once per accepted push.
- FILL: pushes LFSR values until pushed = min(num_ops_i, DEPTH), then DRAIN. full_i=1 before target: error +1, go to DRAIN.
- MIX: each decision cycle, LFSR bit0=1 chooses push, else pop.
  - Push while full_i, or pop while empty_i, flips to the other op.
  - Budget exhausted: go to DRAIN.
- DRAIN: pops until empty_i=1.
  - After each pop accept, wait POP_LAT cycles, sample pop_data_i, then issue the next op.
  - Ordering error: sample < previous drain sample (unsigned). First drain sample has no predecessor.
  - MIX-phase pops only update conservation counters; no ordering check.
- End of DRAIN: conservation error if pushes != pops. Then DONE: busy_o=0, done_o=1; return to IDLE when start_i=0.
- err_cnt_o saturates at 16'hFFFF. err_o = (err_cnt_o != 0). op_cnt_o wraps modulo 2^16.

Optional Feature:
- Macro PQ_TG_WATCHDOG_EN.
- Defined: a counter runs while a request waits for rdy. Reaching TIMEOUT drops the request, adds 1 error, and forces DONE.
- Undefined: no watchdog; a stalled pq hangs the run with busy_o=1.

Test Plan:
- rst_i high 5 cycles, then low -> pq_rst_no low for exactly 16 cycles after rst_i falls; all status outputs 0.
- DEPTH=8, mode 0, num_ops=8, ideal pq -> 8 pushes, 8 pops, op_cnt_o=16, done_o=1, err_cnt_o=0.
- mode 0, num_ops=20, DEPTH=8 -> FILL stops at 8 pushes with no error; drain outputs non-decreasing; op_cnt_o=16.
- Model pq returns one out-of-order value in drain -> err_cnt_o=1, err_o=1, done_o=1.
- mode 1, num_ops=100, push_rdy_i toggled every other cycle -> no request dropped while waiting; push count equals pop count at DONE; err_cnt_o=0.
- rst_i asserted mid-MIX while push_o=1 -> next cycle push_o=0, pq_rst_no=0, busy_o=0; with PQ_TG_WATCHDOG_EN and pop_rdy_i stuck 0, DONE with err_cnt_o=1 after 1024 cycles.

Source files
------------

// File: rtl/pq_fpga_tg.sv
// pq_fpga_tg: reset stretcher, push/pop traffic generator and ordering/conservation checker for one pq.
// Optional request watchdog is built when PQ_TG_WATCHDOG_EN is defined.
package pq_pkg;
    parameter int unsigned DW          = 16;
    parameter int unsigned QUEUE_DEPTH = 8;
endpackage

module pq_fpga_tg #(
    parameter int unsigned       DEPTH    = pq_pkg::QUEUE_DEPTH,
    parameter int unsigned       DW       = pq_pkg::DW,
    parameter int unsigned       LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(16'hACE1),
    parameter int unsigned       RST_HOLD = 16,
    parameter int unsigned       POP_LAT  = 1
`ifdef PQ_TG_WATCHDOG_EN
    ,
    parameter int unsigned       TIMEOUT  = 1024
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          pq_rst_no,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [15:0]   num_ops_i,
    output logic          push_o,
    input  logic          push_rdy_i,
    output logic          pop_o,
    input  logic          pop_rdy_i,
    input  logic          full_i,
    input  logic          empty_i,
    output logic [DW-1:0] push_data_o,
    input  logic [DW-1:0] pop_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [15:0]   err_cnt_o,
    output logic [15:0]   op_cnt_o
);

    typedef enum logic [2:0] {S_RST_HOLD, S_IDLE, S_FILL, S_MIX, S_DRAIN, S_DONE} state_e;

    localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(16'hB400);
    localparam logic [15:0]       DEPTH16 = 16'(DEPTH);

    state_e            state_q, state_d;
    logic [15:0]       hold_q, hold_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [15:0]       num_ops_q, num_ops_d, fill_tgt_q, fill_tgt_d;
    logic [15:0]       push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [15:0]       op_cnt_q, op_cnt_d, err_cnt_q, err_cnt_d, lat_q, lat_d;
    logic              push_q, push_d, pop_q, pop_d, wait_q, wait_d;
    logic              done_q, done_d, pq_rst_n_q, pq_rst_n_d, have_prev_q, have_prev_d;
    logic [DW-1:0]     prev_q, prev_d;
    logic              active, idle_slot, sample, err_inc, want_push;
`ifdef PQ_TG_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]   wd_q, wd_d;
`endif

    assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_RST_HOLD;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;  lfsr_q <= SEED;  num_ops_q <= '0;  fill_tgt_q <= '0;
            push_cnt_q <= '0;  pop_cnt_q <= '0;  op_cnt_q <= '0;  err_cnt_q <= '0;
            lat_q <= '0;  push_q <= 1'b0;  pop_q <= 1'b0;  wait_q <= 1'b0;
            done_q <= 1'b0;  pq_rst_n_q <= 1'b0;  have_prev_q <= 1'b0;  prev_q <= '0;
`ifdef PQ_TG_WATCHDOG_EN
            wd_q <= '0;
`endif
        end else begin
            hold_q <= hold_d;  lfsr_q <= lfsr_d;  num_ops_q <= num_ops_d;  fill_tgt_q <= fill_tgt_d;
            push_cnt_q <= push_cnt_d;  pop_cnt_q <= pop_cnt_d;  op_cnt_q <= op_cnt_d;  err_cnt_q <= err_cnt_d;
            lat_q <= lat_d;  push_q <= push_d;  pop_q <= pop_d;  wait_q <= wait_d;
            done_q <= done_d;  pq_rst_n_q <= pq_rst_n_d;  have_prev_q <= have_prev_d;  prev_q <= prev_d;
`ifdef PQ_TG_WATCHDOG_EN
            wd_q <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;  hold_d = hold_q;  lfsr_d = lfsr_q;  num_ops_d = num_ops_q;  fill_tgt_d = fill_tgt_q;
        push_cnt_d = push_cnt_q;  pop_cnt_d = pop_cnt_q;  op_cnt_d = op_cnt_q;  err_cnt_d = err_cnt_q;
        lat_d = lat_q;  push_d = push_q;  pop_d = pop_q;  wait_d = wait_q;  done_d = done_q;
        pq_rst_n_d = pq_rst_n_q;  have_prev_d = have_prev_q;  prev_d = prev_q;
        sample = 1'b0;  err_inc = 1'b0;  want_push = 1'b0;
`ifdef PQ_TG_WATCHDOG_EN
        wd_d = wd_q;
`endif
        active    = (state_q == S_FILL) || (state_q == S_MIX) || (state_q == S_DRAIN);
        idle_slot = active && !push_q && !pop_q && !wait_q;

        // New ops are only decided in an idle slot, so pq flags already reflect the previous op.
        if (active) begin
            if (wait_q) begin
                if (lat_q == '0) begin
                    wait_d = 1'b0;
                    sample = 1'b1;
                end else begin
                    lat_d = lat_q - 16'd1;
                end
            end
            if (push_q && push_rdy_i) begin
                push_d     = 1'b0;
                push_cnt_d = push_cnt_q + 16'd1;
                op_cnt_d   = op_cnt_q + 16'd1;
                lfsr_d     = lfsr_nxt;
            end
            if (pop_q && pop_rdy_i) begin
                pop_d     = 1'b0;
                pop_cnt_d = pop_cnt_q + 16'd1;
                op_cnt_d  = op_cnt_q + 16'd1;
                if (POP_LAT == 0) begin
                    sample = 1'b1;
                end else begin
                    wait_d = 1'b1;
                    lat_d  = 16'(POP_LAT - 1);
                end
            end
            if (sample && (state_q == S_DRAIN)) begin
                if (have_prev_q && (pop_data_i < prev_q)) err_inc = 1'b1;
                prev_d      = pop_data_i;
                have_prev_d = 1'b1;
            end
        end

        case (state_q)
            S_RST_HOLD: begin
                if (hold_q == 16'(RST_HOLD - 1)) begin
                    state_d    = S_IDLE;
                    pq_rst_n_d = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (start_i) begin
                    num_ops_d   = num_ops_i;
                    fill_tgt_d  = (num_ops_i < DEPTH16) ? num_ops_i : DEPTH16;
                    push_cnt_d  = '0;  pop_cnt_d = '0;  op_cnt_d = '0;  err_cnt_d = '0;
                    done_d      = 1'b0;
                    have_prev_d = 1'b0;
                    if (num_ops_i == '0) state_d = S_DRAIN;
                    else if (mode_i)     state_d = S_MIX;
                    else                 state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (idle_slot) begin
                    if (push_cnt_q == fill_tgt_q) begin
                        state_d = S_DRAIN;
                    end else if (full_i) begin
                        err_inc = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        push_d = 1'b1;
                    end
                end
            end
            S_MIX: begin
                if (idle_slot) begin
                    if (op_cnt_q == num_ops_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        want_push = lfsr_q[0];
                        if (want_push && full_i)        want_push = 1'b0;
                        else if (!want_push && empty_i) want_push = 1'b1;
                        push_d = want_push;
                        pop_d  = !want_push;
                    end
                end
            end
            S_DRAIN: begin
                if (idle_slot) begin
                    if (empty_i) begin
                        if (push_cnt_q != pop_cnt_q) err_inc = 1'b1;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pop_d = 1'b1;
                    end
                end
            end
            S_DONE:  if (!start_i) state_d = S_IDLE;
            default: state_d = S_RST_HOLD;
        endcase

`ifdef PQ_TG_WATCHDOG_EN
        if (active && ((push_q && !push_rdy_i) || (pop_q && !pop_rdy_i))) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                push_d  = 1'b0;
                pop_d   = 1'b0;
                wd_d    = '0;
                err_inc = 1'b1;
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = '0;
        end
`endif

        if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_comb begin
        pq_rst_no   = pq_rst_n_q;
        push_o      = push_q;
        pop_o       = pop_q;
        push_data_o = push_q ? DW'(lfsr_q) : '0;
        busy_o      = (state_q == S_FILL) || (state_q == S_MIX) || (state_q == S_DRAIN);
        done_o      = done_q;
        err_o       = (err_cnt_q != '0);
        err_cnt_o   = err_cnt_q;
        op_cnt_o    = op_cnt_q;
    end

endmodule

// File: tb/tb_pq_fpga_tg.sv
// Bench for pq_fpga_tg: behavioural min-priority queue model plus end-of-run scoreboard.
`timescale 1ns/1ps
module tb_pq_fpga_tg;
    localparam int          DEPTH = 8;
    localparam int          DW    = 16;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, start_i = 1'b0, mode_i = 1'b0;
    logic [15:0]   num_ops_i = '0;
    logic          push_rdy_i = 1'b1, pop_rdy_i = 1'b1;
    logic          full_i = 1'b0, empty_i = 1'b1;
    logic [DW-1:0] pop_data_i = '0;
    logic          pq_rst_no, push_o, pop_o, busy_o, done_o, err_o;
    logic [DW-1:0] push_data_o;
    logic [15:0]   err_cnt_o, op_cnt_o;

    pq_fpga_tg #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .pq_rst_no(pq_rst_no), .start_i(start_i), .mode_i(mode_i),
        .num_ops_i(num_ops_i), .push_o(push_o), .push_rdy_i(push_rdy_i), .pop_o(pop_o),
        .pop_rdy_i(pop_rdy_i), .full_i(full_i), .empty_i(empty_i), .push_data_o(push_data_o),
        .pop_data_i(pop_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_cnt_o(err_cnt_o), .op_cnt_o(op_cnt_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural pq: registered full/empty, pop data valid one cycle after accept.
    logic [DW-1:0] items[$];
    logic [DW-1:0] mv;
    int            tot_pushes = 0, tot_pops = 0;
    int            corrupt_at = -1;
    logic          acc_push = 1'b0, pend_push = 1'b0, pend_pop = 1'b0;
    logic [DW-1:0] acc_data = '0, pend_data = '0;

    function automatic logic [DW-1:0] take_min();
        int mi = 0;
        logic [DW-1:0] v;
        if (items.size() == 0) return '0;
        for (int i = 1; i < items.size(); i++)
            if (items[i] < items[mi]) mi = i;
        v = items[mi];
        items.delete(mi);
        return v;
    endfunction

    always @(posedge clk) begin
        acc_push  <= push_o && push_rdy_i && !rst_i;
        acc_data  <= push_data_o;
        pend_push <= push_o && !push_rdy_i && !rst_i;
        pend_data <= push_data_o;
        pend_pop  <= pop_o && !pop_rdy_i && !rst_i;
        if (pq_rst_no !== 1'b1) begin
            items.delete();
        end else begin
            if ((push_o === 1'b1) && push_rdy_i) begin
                items.push_back(push_data_o);
                tot_pushes <= tot_pushes + 1;
            end
            if ((pop_o === 1'b1) && pop_rdy_i) begin
                mv = take_min();
                pop_data_i <= (tot_pops == corrupt_at) ? '0 : mv;
                tot_pops   <= tot_pops + 1;
            end
        end
        full_i  <= (items.size() >= DEPTH);
        empty_i <= (items.size() == 0);
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] exp_lfsr = SEED;
    logic        toggle_rdy = 1'b0;

    // Every clock advance of the stimulus goes through here so streaming checks stay in one process.
    task automatic tick();
        @(negedge clk);
        if (rst_i) begin
            exp_lfsr = SEED;
        end else begin
            if (acc_push) begin
                check("push_lfsr", acc_data, exp_lfsr);
                exp_lfsr = lfsr_step(exp_lfsr);
            end
            if (pend_push) begin
                check("push_held", push_o, 1);
                check("push_data_held", push_data_o, pend_data);
            end
            if (pend_pop) check("pop_held", pop_o, 1);
        end
        if (toggle_rdy) push_rdy_i = ~push_rdy_i;
    endtask

    typedef struct packed {
        logic [15:0] op;
        logic [15:0] err;
        logic        op_known;
        logic        cons;
    } exp_t;
    exp_t sb[$];

    task automatic run(input string name, input logic mode, input logic [15:0] n,
                       input logic [15:0] exp_op, input logic [15:0] exp_err,
                       input logic op_known, input logic cons);
        exp_t e;
        int   p0, q0, budget;
        logic got;
        e.op = exp_op;  e.err = exp_err;  e.op_known = op_known;  e.cons = cons;
        sb.push_back(e);
        p0 = tot_pushes;  q0 = tot_pops;
        mode_i = mode;  num_ops_i = n;  start_i = 1'b1;
        tick();
        start_i = 1'b0;
        got = 1'b0;
        budget = 4000;
        while (!got && budget > 0) begin
            tick();
            budget--;
            if (done_o) got = 1'b1;
        end
        e = sb.pop_front();
        check({name, "_done"}, got, 1);
        if (got) begin
            check({name, "_busy"}, busy_o, 0);
            check({name, "_err_cnt"}, err_cnt_o, e.err);
            check({name, "_err_o"}, err_o, (e.err != 0));
            if (e.op_known) check({name, "_op_cnt"}, op_cnt_o, e.op);
            else            check({name, "_op_cnt"}, op_cnt_o, 16'(tot_pushes - p0 + tot_pops - q0));
            if (e.cons)     check({name, "_conserve"}, tot_pushes - p0, tot_pops - q0);
        end
        tick();
        tick();
    endtask

    task automatic release_reset();
        rst_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("pq_rst_hold", pq_rst_no, (k < 16) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 5; i++) tick();
        check("rst_pq_rst_no", pq_rst_no, 0);
        check("rst_push_o", push_o, 0);
        check("rst_pop_o", pop_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err_o", err_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_op_cnt", op_cnt_o, 0);
        check("rst_push_data", push_data_o, 0);
        release_reset();
        tick();
        check("idle_busy", busy_o, 0);

        run("fill8", 1'b0, 16'd8, 16'd16, 16'd0, 1'b1, 1'b1);
        run("fill20", 1'b0, 16'd20, 16'd16, 16'd0, 1'b1, 1'b1);
        corrupt_at = tot_pops + 3;
        run("order_err", 1'b0, 16'd8, 16'd16, 16'd1, 1'b1, 1'b1);
        corrupt_at = -1;
        toggle_rdy = 1'b1;
        run("mix100", 1'b1, 16'd100, 16'd0, 16'd0, 1'b0, 1'b1);
        toggle_rdy = 1'b0;
        push_rdy_i = 1'b1;
        run("zero_ops", 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1);

        // Abort a MIX run while a push is stalled waiting for ready.
        push_rdy_i = 1'b0;
        mode_i = 1'b1;  num_ops_i = 16'd100;  start_i = 1'b1;
        tick();
        start_i = 1'b0;
        budget = 50;
        while (!push_o && budget > 0) begin
            tick();
            budget--;
        end
        check("abort_push_pending", push_o, 1);
        rst_i = 1'b1;
        tick();
        check("abort_push_o", push_o, 0);
        check("abort_pop_o", pop_o, 0);
        check("abort_pq_rst_no", pq_rst_no, 0);
        check("abort_busy", busy_o, 0);
        check("abort_op_cnt", op_cnt_o, 0);
        check("abort_push_data", push_data_o, 0);
        tick();
        push_rdy_i = 1'b1;
        release_reset();
        run("refill8", 1'b0, 16'd8, 16'd16, 16'd0, 1'b1, 1'b1);

`ifdef PQ_TG_WATCHDOG_EN
        pop_rdy_i = 1'b0;
        run("watchdog", 1'b0, 16'd4, 16'd4, 16'd1, 1'b1, 1'b0);
        pop_rdy_i = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
